// File: rtl/inertial_delay_pkg.sv
// inertial_delay_pkg
//   Shared definitions for the inertial/transport delay filter:
//     - mode_e         : operating mode encoding (inertial = 0, transport = 1)
//     - *_DEFAULT      : default parameter values used by the filter and its channels
//     - clog2()        : constant ceil(log2) used to size the per-channel run counter
package inertial_delay_pkg;

    typedef enum logic {
        MODE_INERTIAL  = 1'b0,
        MODE_TRANSPORT = 1'b1
    } mode_e;

    localparam int unsigned CHANNELS_DEFAULT = 4;
    localparam int unsigned DELAY_DEFAULT    = 10;
    localparam int unsigned GCW_DEFAULT      = 8;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned remaining;
        result    = 0;
        remaining = (value > 0) ? value - 1 : 0;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/inertial_delay_chan.sv
// inertial_delay_chan
//   One channel of the inertial/transport delay filter.
//   Inertial mode: a din level must be seen on DELAY consecutive edges before it reaches dout;
//   shorter excursions are dropped. Transport mode: dout is din delayed by exactly DELAY edges
//   through a shift line whose final stage is the dout register itself.
//
//   Optional feature (macro INERTIAL_DELAY_GLITCH_CNT_EN): saturating count of pulses swallowed
//   in inertial mode, cleared by glitch_clr.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset
//   mode_cur   in   registered mode shared by all channels
//   flush      in   mode is changing this edge: drop in-flight changes, hold dout
//   din        in   channel input
//   glitch_clr in   clear glitch counter (macro only)
//   glitch_cnt out  swallowed-pulse count (macro only)
//   dout       out  delayed/filtered output
//   pending    out  a din change is in flight (forced low while reset is asserted)
module inertial_delay_chan
    import inertial_delay_pkg::*;
#(
    parameter int unsigned DELAY = DELAY_DEFAULT
`ifdef INERTIAL_DELAY_GLITCH_CNT_EN
    ,
    parameter int unsigned GCW   = GCW_DEFAULT
`endif
) (
    input  logic           clock,
    input  logic           reset,
    input  mode_e          mode_cur,
    input  logic           flush,
    input  logic           din,
`ifdef INERTIAL_DELAY_GLITCH_CNT_EN
    input  logic           glitch_clr,
    output logic [GCW-1:0] glitch_cnt,
`endif
    output logic           dout,
    output logic           pending
);

    localparam int unsigned CW = clog2(DELAY + 1);
    // dout_q is the last transport stage, so only DELAY-1 extra taps are stored.
    localparam int unsigned SW = (DELAY > 1) ? DELAY - 1 : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] shift_q, shift_d, shifted;
    logic          dout_q, dout_d;
    logic          line_out;
    logic          taps_differ;

    // Shift din into tap 0; the top tap falls off into dout.
    assign shifted     = SW'({shift_q, din});
    assign line_out    = (DELAY == 1) ? din : shift_q[SW-1];
    assign taps_differ = (DELAY > 1) && (shift_q != {SW{dout_q}});

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        if (flush) begin
            // Restart in the new mode from a clean state that matches dout.
            cnt_d   = '0;
            shift_d = {SW{dout_q}};
        end else if (mode_cur == MODE_TRANSPORT) begin
            shift_d = shifted;
            dout_d  = line_out;
        end else begin
            if (din == dout_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                dout_d = din;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
            dout_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        pending = 1'b0;
        if (!reset) begin
            pending = (din != dout_q);
            if (mode_cur == MODE_TRANSPORT) begin
                pending = pending | taps_differ;
            end
        end
    end

    assign dout = dout_q;

`ifdef INERTIAL_DELAY_GLITCH_CNT_EN
    logic [GCW-1:0] glitch_q, glitch_d;
    logic           swallow;

    // A partial run that ends with din back at the dout level is a swallowed pulse.
    assign swallow = !flush && (mode_cur == MODE_INERTIAL) && (cnt_q != '0) && (din == dout_q);

    always_comb begin
        glitch_d = glitch_q;
        if (glitch_clr) begin
            glitch_d = '0;
        end else if (swallow && (glitch_q != '1)) begin
            glitch_d = glitch_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule

// File: rtl/inertial_delay_filter.sv
// inertial_delay_filter
//   Clocked replacement for continuous-assign wire delays. Each of CHANNELS 1-bit inputs is
//   delayed by DELAY clock cycles, either inertially (pulses shorter than DELAY are dropped)
//   or as a pure transport delay. A change of mode flushes all channels on the edge where it
//   is seen; the new mode takes effect from the following edge.
//
//   Optional feature macro: INERTIAL_DELAY_GLITCH_CNT_EN adds glitch_clr/glitch_cnt, a
//   per-channel saturating count of pulses swallowed in inertial mode.
//
// Parameters:
//   CHANNELS  number of independent channels (>= 1)
//   DELAY     delay in clock cycles (>= 1)
//   GCW       glitch counter width per channel (macro only)
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-high reset
//   mode        in   0 = inertial, 1 = transport; sampled every edge
//   din         in   [CHANNELS]      channel inputs
//   glitch_clr  in   clears all glitch counters (macro only)
//   glitch_cnt  out  [CHANNELS*GCW]  channel i at [i*GCW +: GCW] (macro only)
//   dout        out  [CHANNELS]      delayed/filtered outputs
//   pending     out  [CHANNELS]      channel has a change in flight
module inertial_delay_filter
    import inertial_delay_pkg::*;
#(
    parameter int unsigned CHANNELS = CHANNELS_DEFAULT,
    parameter int unsigned DELAY    = DELAY_DEFAULT,
    parameter int unsigned GCW      = GCW_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    mode,
    input  logic [CHANNELS-1:0]     din,
`ifdef INERTIAL_DELAY_GLITCH_CNT_EN
    input  logic                    glitch_clr,
    output logic [CHANNELS*GCW-1:0] glitch_cnt,
`endif
    output logic [CHANNELS-1:0]     dout,
    output logic [CHANNELS-1:0]     pending
);

    if ((CHANNELS == 0) || (DELAY == 0) || (GCW == 0)) begin : g_bad_params
        $error("inertial_delay_filter: CHANNELS, DELAY and GCW must all be >= 1");
    end

    mode_e mode_q;
    logic  flush;

    assign flush = (mode_e'(mode) != mode_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q <= MODE_INERTIAL;
        end else begin
            mode_q <= mode_e'(mode);
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        inertial_delay_chan #(
            .DELAY (DELAY)
`ifdef INERTIAL_DELAY_GLITCH_CNT_EN
            ,
            .GCW   (GCW)
`endif
        ) u_chan (
            .clock      (clock),
            .reset      (reset),
            .mode_cur   (mode_q),
            .flush      (flush),
            .din        (din[ch]),
`ifdef INERTIAL_DELAY_GLITCH_CNT_EN
            .glitch_clr (glitch_clr),
            .glitch_cnt (glitch_cnt[ch*GCW +: GCW]),
`endif
            .dout       (dout[ch]),
            .pending    (pending[ch])
        );
    end

endmodule

// File: tb/tb_inertial_delay_filter.sv
module tb_inertial_delay_filter;

    localparam int unsigned CH = 4;
    localparam int unsigned DL = 10;
    localparam int unsigned GW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          mode;
    logic [CH-1:0] din;
    logic [CH-1:0] dout;
    logic [CH-1:0] pending;
`ifdef INERTIAL_DELAY_GLITCH_CNT_EN
    logic             glitch_clr;
    logic [CH*GW-1:0] glitch_cnt;
`endif

    inertial_delay_filter #(
        .CHANNELS (CH),
        .DELAY    (DL),
        .GCW      (GW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mode       (mode),
        .din        (din),
`ifdef INERTIAL_DELAY_GLITCH_CNT_EN
        .glitch_clr (glitch_clr),
        .glitch_cnt (glitch_cnt),
`endif
        .dout       (dout),
        .pending    (pending)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: per-channel history of edge samples, newest in bit 0.
    logic [DL-1:0] m_hist [CH];
    logic          m_dout [CH];
    int            m_gcnt [CH];
    logic          m_mode;

    typedef struct {
        logic [CH-1:0]    dout;
        logic [CH-1:0]    pending;
        logic [CH*GW-1:0] gcnt;
    } exp_t;

    exp_t sb[$];

    task automatic model_edge(input logic r, input logic m, input logic [CH-1:0] d,
                              input logic c);
        logic prev;
        logic swallow;
        for (int ch = 0; ch < CH; ch++) begin
            swallow = 1'b0;
            if (r) begin
                m_hist[ch] = '0;
                m_dout[ch] = 1'b0;
                m_gcnt[ch] = 0;
            end else begin
                if (m != m_mode) begin
                    m_hist[ch] = {DL{m_dout[ch]}};
                end else begin
                    prev       = m_hist[ch][0];
                    m_hist[ch] = {m_hist[ch][DL-2:0], d[ch]};
                    if (m_mode == 1'b0) begin
                        swallow = (prev != m_dout[ch]) && (d[ch] == m_dout[ch]);
                        if ((m_hist[ch] == {DL{1'b1}}) && !m_dout[ch]) m_dout[ch] = 1'b1;
                        else if ((m_hist[ch] == {DL{1'b0}}) && m_dout[ch]) m_dout[ch] = 1'b0;
                    end else begin
                        m_dout[ch] = m_hist[ch][DL-1];
                    end
                end
                if (c) m_gcnt[ch] = 0;
                else if (swallow && (m_gcnt[ch] < 255)) m_gcnt[ch]++;
            end
        end
        m_mode = r ? 1'b0 : m;
    endtask

    task automatic step(input logic r, input logic m, input logic [CH-1:0] d, input logic c);
        exp_t e;
        reset = r;
        mode  = m;
        din   = d;
`ifdef INERTIAL_DELAY_GLITCH_CNT_EN
        glitch_clr = c;
`endif
        model_edge(r, m, d, c);
        for (int ch = 0; ch < CH; ch++) begin
            e.dout[ch] = m_dout[ch];
            if (r) e.pending[ch] = 1'b0;
            else if (m_mode == 1'b0) e.pending[ch] = (d[ch] != m_dout[ch]);
            else e.pending[ch] = (d[ch] != m_dout[ch]) || (m_hist[ch] != {DL{m_dout[ch]}});
            e.gcnt[ch*GW +: GW] = GW'(m_gcnt[ch]);
        end
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check("sb_dout", 32'(dout), 32'(e.dout));
        check("sb_pending", 32'(pending), 32'(e.pending));
`ifdef INERTIAL_DELAY_GLITCH_CNT_EN
        check("sb_glitch_cnt", glitch_cnt, e.gcnt);
`endif
    endtask

    typedef struct {
        logic          r;
        logic          m;
        logic [CH-1:0] d;
        logic [CH-1:0] exp_dout;
    } vec_t;

    vec_t tbl[$];

    initial begin
        reset = 1'b1;
        mode  = 1'b0;
        din   = '0;
`ifdef INERTIAL_DELAY_GLITCH_CNT_EN
        glitch_clr = 1'b0;
`endif
        m_mode = 1'b0;

        // Reset with din high, then din held: dout rises on the 10th edge after release.
        for (int i = 0; i < 2; i++) tbl.push_back('{1'b1, 1'b0, 4'hF, 4'h0});
        for (int i = 0; i < 10; i++) tbl.push_back('{1'b0, 1'b0, 4'hF, (i == 9) ? 4'hF : 4'h0});
        // Return to 0 so channel 0 can show a clean 0->1 step.
        for (int i = 0; i < 10; i++) tbl.push_back('{1'b0, 1'b0, 4'h0, (i == 9) ? 4'h0 : 4'hF});
        // din[0] rises and holds; din[1] is a 5-edge pulse that must be swallowed.
        for (int i = 0; i < 12; i++)
            tbl.push_back('{1'b0, 1'b0, (i < 5) ? 4'h3 : 4'h1, (i >= 9) ? 4'h1 : 4'h0});

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].m, tbl[i].d, 1'b0);
            check("tbl_dout", 32'(dout), 32'(tbl[i].exp_dout));
        end
`ifdef INERTIAL_DELAY_GLITCH_CNT_EN
        check("glitch_ch1_after_pulse", 32'(glitch_cnt[15:8]), 32'd1);
`endif

        // Transport: flush edge, then a 5-edge pulse on din[1] must reappear intact.
        step(1'b0, 1'b1, 4'h1, 1'b0);
        check("tr_flush_hold", 32'(dout), 32'h1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, (i < 5) ? 4'h3 : 4'h1, 1'b0);
            check("tr_dout1", 32'(dout[1]), 32'((i >= 9) && (i <= 13)));
            check("tr_dout0", 32'(dout[0]), 32'd1);
        end
`ifdef INERTIAL_DELAY_GLITCH_CNT_EN
        check("glitch_ch1_transport", 32'(glitch_cnt[15:8]), 32'd1);
`endif

        // Mode switch mid-flight: inertial count 4 on din[2], then switch to transport.
        step(1'b0, 1'b0, 4'h1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 4'h5, 1'b0);
            check("sw_count_dout2", 32'(dout[2]), 32'd0);
        end
        step(1'b0, 1'b1, 4'h5, 1'b0);
        check("sw_flush_dout2", 32'(dout[2]), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 4'h5, 1'b0);
            check("sw_after_dout2", 32'(dout[2]), 32'(i == 9));
        end

        // Reset mid-count discards the in-flight change on din[3].
        step(1'b0, 1'b0, 4'hD, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 4'hD, 1'b0);
            check("rst_count_dout3", 32'(dout[3]), 32'd0);
        end
        step(1'b1, 1'b0, 4'hD, 1'b0);
        check("rst_mid_dout", 32'(dout), 32'h0);
        check("rst_mid_pending", 32'(pending), 32'h0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 4'hD, 1'b0);
            check("rst_release_dout", 32'(dout), (i == 9) ? 32'hD : 32'h0);
        end

        // Many swallowed pulses on din[0]; counter saturates, then clear beats a swallow.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'h0, 1'b0);
        for (int p = 0; p < 300; p++) begin
            for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'h1, 1'b0);
            for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'h0, 1'b0);
        end
        check("pulses_dout", 32'(dout), 32'h0);
`ifdef INERTIAL_DELAY_GLITCH_CNT_EN
        check("glitch_ch0_saturated", 32'(glitch_cnt[7:0]), 32'd255);
`endif
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'h1, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b1);
`ifdef INERTIAL_DELAY_GLITCH_CNT_EN
        check("glitch_ch0_cleared", 32'(glitch_cnt[7:0]), 32'd0);
`endif
        step(1'b0, 1'b0, 4'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
